// File: rtl/pc_fetch_unit.sv
// Program-counter register plus single-outstanding instruction fetch with a one-entry decode buffer.
// Redirects from execute override everything except reset and squash any fetch still in flight.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Next_PC,
    output logic [31:0] PC_reg_out,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic        squash_q, squash_d;
    logic        misalign_q, misalign_d;

    logic req;
    logic xfer;
    logic drain;
    logic load;

    // A request only goes out when the buffer will be free by the time data returns.
    assign req   = (state_q == S_REQ) && (!if_valid_q || id_ready);
    assign xfer  = req && imem_gnt;
    assign drain = if_valid_q && id_ready;
    assign load  = (state_q == S_WAIT) && imem_rvalid && !squash_q && !branch_taken;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        squash_d   = squash_q;
        misalign_d = branch_taken && (branch_target[1:0] != 2'b00);

        case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ: begin
                if (xfer) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d  = S_REQ;
                    squash_d = 1'b0;
                end
            end
            default: state_d = S_RESET;
        endcase

        if (drain) begin
            if_valid_d = 1'b0;
        end

        if (load) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = Next_PC;
        end

        // Redirect wins over any load; a fetch that is still outstanding becomes stale.
        if (branch_taken) begin
            pc_d       = {branch_target[31:2], 2'b00};
            if_valid_d = 1'b0;
            if ((state_q == S_WAIT) && !imem_rvalid) begin
                squash_d = 1'b1;
            end
            if ((state_q == S_REQ) && xfer) begin
                squash_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_PC;
            if_instr_q <= NOP_INSTR;
            if_pc_q    <= 32'h0000_0000;
            if_valid_q <= 1'b0;
            squash_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            squash_q   <= squash_d;
            misalign_q <= misalign_d;
        end
    end

    assign PC_reg_out   = pc_q;
    assign imem_req     = req;
    assign imem_addr    = pc_q;
    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_pc        = if_pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic, checked against a
// transaction-level model of the fetch stream (fetch PC, one in-flight fetch, one-entry buffer).
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Next_PC;
    logic [31:0] PC_reg_out;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        misalign_err;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state: where fetch is, whether a fetch is in flight and stale, buffer contents.
    logic [31:0] mPc, mInstr, mIpc;
    logic        mValid, mBoot, mInflight, mStale, mMis;

    // Instruction memory model.
    logic        memBusy;
    int          memCnt;
    logic [31:0] memAddr;
    int          latLo, latHi;
    int          stray;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .Next_PC      (Next_PC),
        .PC_reg_out   (PC_reg_out),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    // The PC+4 adder stage sitting next to the fetch unit.
    assign Next_PC = PC_reg_out + 32'd4;

    function automatic logic [31:0] wordOf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkRegs();
        checkOutput("PC_reg_out", PC_reg_out, mPc);
        checkOutput("if_valid", {31'd0, if_valid}, {31'd0, mValid});
        if (mValid) begin
            checkOutput("if_instr", if_instr, mInstr);
            checkOutput("if_pc", if_pc, mIpc);
        end
        checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, mMis});
    endtask

    task automatic assertReset(input int strayCycles);
        reset = 1'b1;
        #1;
        mPc = RESET_PC; mInstr = 32'h0000_0013; mIpc = 32'h0;
        mValid = 1'b0; mBoot = 1'b1; mInflight = 1'b0; mStale = 1'b0; mMis = 1'b0;
        memBusy = 1'b0; memCnt = 0; stray = 0;
        checkRegs();
        checkOutput("reset_if_instr", if_instr, 32'h0000_0013);
        checkOutput("reset_if_pc", if_pc, 32'h0);
        checkOutput("reset_imem_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stray = strayCycles;
    endtask

    // One clock cycle: drive inputs, check the request side, clock, then check registered state.
    task automatic applyStimulus(input logic br, input logic [31:0] tgt, input logic rdy, input logic gnt);
        logic        rv, respNow, expReq, dutXfer, resp, accept, xferM;
        logic [31:0] dutAddr;
        respNow       = memBusy && (memCnt == 0);
        rv            = respNow || (stray > 0);
        branch_taken  = br;
        branch_target = tgt;
        id_ready      = rdy;
        imem_gnt      = gnt;
        imem_rvalid   = rv;
        imem_rdata    = respNow ? wordOf(memAddr) : 32'hDEAD_BEEF;
        #2;
        expReq = !mBoot && !mInflight && (!mValid || rdy);
        checkOutput("imem_req", {31'd0, imem_req}, {31'd0, expReq});
        if (expReq) begin
            checkOutput("imem_addr", imem_addr, mPc);
        end
        dutXfer = imem_req && gnt;
        dutAddr = imem_addr;
        @(posedge clk);

        if (respNow) memBusy = 1'b0;
        else if (memBusy) memCnt--;
        if (stray > 0) stray--;
        if (dutXfer) begin
            memBusy = 1'b1;
            memCnt  = $urandom_range(latHi, latLo);
            memAddr = dutAddr;
        end

        resp   = mInflight && rv;
        accept = resp && !mStale && !br;
        xferM  = expReq && gnt;
        if (mValid && rdy) mValid = 1'b0;
        if (accept) begin
            mValid = 1'b1;
            mInstr = wordOf(mPc);
            mIpc   = mPc;
            mPc    = mPc + 32'd4;
        end
        if (resp) begin
            mInflight = 1'b0;
            mStale    = 1'b0;
        end else if (mInflight && br) begin
            mStale = 1'b1;
        end
        if (xferM) begin
            mInflight = 1'b1;
            mStale    = br;
        end
        if (br) begin
            mPc    = {tgt[31:2], 2'b00};
            mValid = 1'b0;
        end
        mMis  = br && (tgt[1:0] != 2'b00);
        mBoot = 1'b0;
        #1;
        checkRegs();
    endtask

    initial begin
        logic        br, rdy, gnt;
        logic [31:0] tgt;
        reset = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        id_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        latLo = 0; latHi = 0;
        memBusy = 1'b0; memCnt = 0; memAddr = 32'h0; stray = 0;
        #1;
        assertReset(0);

        $display("[TB] sequential fetch after reset, then decode stall");
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        latLo = 2; latHi = 2;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] redirect while waiting on memory");
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        latLo = 0; latHi = 0;
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] misaligned redirect and redirect alongside rvalid");
        applyStimulus(1'b1, 32'h0000_0102, 1'b1, 1'b1);
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] wrap-around at top of address space");
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (7) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] reset during outstanding fetch with stray rvalid");
        latLo = 3; latHi = 3;
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        assertReset(2);
        latLo = 0; latHi = 0;
        repeat (5) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] random traffic");
        latLo = 0; latHi = 3;
        for (int i = 0; i < 3000; i++) begin
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            gnt = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else tgt = $urandom & 32'h0000_0FFF;
            applyStimulus(br, tgt, rdy, gnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program-counter register and the instruction-fetch handshake.
- Drives PC_reg_out to the PC+4 adder stage and consumes its Next_PC result.
- Issues one outstanding request at a time to instruction memory and buffers the returned word for decode.
- Applies branch/jump redirects from execute, squashing any in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
Next_PC  in  32  PC_reg_out+4 from adder stage.
PC_reg_out  out  32  current fetch PC, to adder stage.
branch_taken  in  1  redirect pulse from execute.
branch_target  in  32  redirect address.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address (= PC_reg_out).
imem_gnt  in  1  memory accepts request this cycle.
imem_rvalid  in  1  read data valid.
imem_rdata  in  32  instruction word.
if_valid  out  1  decode buffer holds a valid instruction.
if_instr  out  32  buffered instruction.
if_pc  out  32  PC of buffered instruction.
id_ready  in  1  decode consumes buffer this cycle when if_valid=1.
misalign_err  out  1  one-cycle pulse: redirect target not word-aligned.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: PC_reg_out=RESET_PC, state=S_RESET, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, imem_req=0, misalign_err=0, squash=0.
- Reset asserted mid-transaction aborts everything immediately. Any rvalid arriving after reset release while in S_RESET or S_REQ is ignored.
- Handshakes:
  - Request transfers when imem_req & imem_gnt.
  - Buffer drains when if_valid & id_ready.
  - Only one request is outstanding at a time.
- FSM states:
  - S_RESET: imem_req=0. Always moves to S_REQ next cycle.
  - S_REQ: imem_req = (!if_valid | id_ready); imem_addr = PC_reg_out. On transfer, go to S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid:
    - if squash=1: discard data, clear squash, go to S_REQ; PC unchanged.
    - else: if_instr<=imem_rdata, if_pc<=PC_reg_out, if_valid<=1, PC_reg_out<=Next_PC, go to S_REQ.
- Buffer invariant: a request issues only when the buffer is empty or draining that cycle, so the buffer is always free on rvalid. No overflow path exists.
- Buffer drain: id_ready with if_valid=1 and no load that cycle clears if_valid. A simultaneous drain and load leaves if_valid=1 with the new word.
- Redirect (branch_taken=1) has highest priority and acts in any state except S_RESET, where it is taken but the FSM still moves to S_REQ:
  - PC_reg_out <= {branch_target[31:2],2'b00}.
  - if_valid <= 0 (flush, overrides a same-cycle load). Decode does not sample the flushed entry.
  - In S_WAIT without rvalid that cycle: squash<=1, stay in S_WAIT.
  - In S_WAIT with rvalid that cycle: data dropped, go to S_REQ, squash stays 0.
  - In S_REQ with a transfer that cycle: go to S_WAIT with squash<=1.
  - In S_REQ without a transfer: stay in S_REQ; the next request uses the new PC.
  - The Next_PC load in the same cycle is overridden by the redirect.
- misalign_err = 1 for exactly the cycle after branch_taken when branch_target[1:0]!=0; 0 otherwise.
- Arithmetic: no internal addition; Next_PC is used as-is, so wrap-around 32'hFFFF_FFFC -> 0 follows the adder.
- Latency: request-to-if_valid = imem response latency + 1 cycle (registered buffer).

Test Plan:
- Reset release, memory with gnt=1 and rvalid one cycle later: imem_addr sequence 0,4,8. if_pc follows 0,4,8 with matching if_instr. if_valid first rises 3 cycles after reset release.
- id_ready=0 held with buffer full: imem_req=0, PC frozen at 4, if_instr stable. Raise id_ready: the request to 4 issues the same cycle.
- branch_taken with target 0x100 while in S_WAIT: the returning word for the old PC is discarded (if_valid stays 0). Next request address=0x100; if_pc=0x100.
- branch_taken with target 0x102: misalign_err pulses one cycle; next imem_addr=0x100.
- branch_taken in the same cycle as rvalid and id_ready=1: if_valid=0 next cycle, PC_reg_out=target, no squash left pending.
- Assert reset in S_WAIT, then release; stray rvalid in the next 2 cycles: outputs at reset values, first request address=RESET_PC, stray data never appears on if_instr.
